// File: rtl/dmem_responder_pkg.sv
// Shared constants for dmem_responder: address regions, MMIO register offsets
// and FIFO status layout.
package dmem_responder_pkg;

   localparam int unsigned DATA_W = 32;

   // Region select on DMEM_address[31:28]
   localparam logic [3:0] REGION_RAM  = 4'h0;
   localparam logic [3:0] REGION_MMIO = 4'h1;

   // MMIO register select on DMEM_address[3:2]
   typedef enum logic [1:0] {
      MMIO_LED       = 2'd0,
      MMIO_CYCLE     = 2'd1,
      MMIO_FIFO_DATA = 2'd2,
      MMIO_FIFO_STAT = 2'd3
   } mmio_off_e;

   // Sticky overflow flag position in FIFO_STAT
   localparam int unsigned OVF_BIT = 31;

endpackage

// File: rtl/dmem_out_fifo.sv
// Synchronous output FIFO with occupancy count; a push is accepted when not
// full or when a pop frees a slot in the same cycle.
module dmem_out_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 32
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   // Storage is not reset; an empty count makes stale entries invisible
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus MMIO (LED, cycle counter, output FIFO).
// The output FIFO is built only when DMEM_OUT_FIFO_EN is defined.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned DEPTH      = 1024,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] DMEM_address,
   input  logic [DATA_W-1:0] write_data,
   input  logic              DMEM_WRITE,
   output logic [DATA_W-1:0] read_data,
   output logic [DATA_W-1:0] led_out,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [3:0]        region;
   mmio_off_e         mmio_off;
   logic [AW-1:0]     ram_idx;
   logic              wr_ram;
   logic              wr_led;
   logic              wr_cycle;
   logic              wr_fifo;
   logic              wr_stat;
   logic [DATA_W-1:0] cycle;
   logic [DATA_W-1:0] stat_word;
   logic              unused_bits;

   logic [DATA_W-1:0] ram [DEPTH];

   assign region   = DMEM_address[31:28];
   assign mmio_off = mmio_off_e'(DMEM_address[3:2]);
   assign ram_idx  = DMEM_address[AW+1:2];

   // Store decode
   always_comb begin
      wr_ram   = 1'b0;
      wr_led   = 1'b0;
      wr_cycle = 1'b0;
      wr_fifo  = 1'b0;
      wr_stat  = 1'b0;
      if (DMEM_WRITE) begin
         if (region == REGION_RAM) begin
            wr_ram = 1'b1;
         end else if (region == REGION_MMIO) begin
            case (mmio_off)
               MMIO_LED:       wr_led   = 1'b1;
               MMIO_CYCLE:     wr_cycle = 1'b1;
               MMIO_FIFO_DATA: wr_fifo  = 1'b1;
               MMIO_FIFO_STAT: wr_stat  = 1'b1;
               default:        wr_led   = 1'b0;
            endcase
         end
      end
   end

   // Word RAM; contents survive reset
   always_ff @(posedge clock) begin
      if (wr_ram) begin
         ram[ram_idx] <= write_data;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         led_out <= '0;
      end else if (wr_led) begin
         led_out <= write_data;
      end
   end

   // Free-running cycle counter; a clearing store wins over the increment
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cycle <= '0;
      end else if (wr_cycle) begin
         cycle <= '0;
      end else begin
         cycle <= cycle + DATA_W'(1);
      end
   end

`ifdef DMEM_OUT_FIFO_EN
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_pop;
   logic [CW-1:0] fifo_count;
   logic          overflow;

   assign out_valid = ~fifo_empty;
   assign fifo_pop  = out_valid & out_ready;

   dmem_out_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (wr_fifo),
      .push_data (write_data),
      .pop       (fifo_pop),
      .head      (out_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Sticky overflow: set only when a push is dropped
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (wr_stat) begin
         overflow <= 1'b0;
      end else if (wr_fifo && fifo_full && !fifo_pop) begin
         overflow <= 1'b1;
      end
   end

   always_comb begin
      stat_word          = DATA_W'(fifo_count);
      stat_word[OVF_BIT] = overflow;
   end

   assign unused_bits = ^{DMEM_address[27:AW+2], DMEM_address[1:0]};
`else
   assign out_valid   = 1'b0;
   assign out_data    = '0;
   assign stat_word   = '0;
   assign unused_bits = ^{DMEM_address[27:AW+2], DMEM_address[1:0],
                          out_ready, wr_fifo, wr_stat};
`endif

   // Zero-latency load path from pre-edge state
   always_comb begin
      read_data = '0;
      if (region == REGION_RAM) begin
         read_data = ram[ram_idx];
      end else if (region == REGION_MMIO) begin
         case (mmio_off)
            MMIO_LED:       read_data = led_out;
            MMIO_CYCLE:     read_data = cycle;
            MMIO_FIFO_DATA: read_data = '0;
            MMIO_FIFO_STAT: read_data = stat_word;
            default:        read_data = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed table, multi-cycle FIFO and
// reset sequences, then random traffic against a queue-based memory-map model.
module tb_dmem_responder;

   localparam int unsigned DEPTH = 1024;
   localparam int unsigned FD    = 8;

   logic        clock;
   logic        reset;
   logic [31:0] DMEM_address;
   logic [31:0] write_data;
   logic        DMEM_WRITE;
   logic [31:0] read_data;
   logic [31:0] led_out;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   logic [31:0] mram [int unsigned];
   logic [31:0] mled;
   logic [31:0] mcyc;
   logic [31:0] mq [$];
   bit          movf;

   dmem_responder #(.DEPTH(DEPTH), .FIFO_DEPTH(FD)) dut (
      .clock        (clock),
      .reset        (reset),
      .DMEM_address (DMEM_address),
      .write_data   (write_data),
      .DMEM_WRITE   (DMEM_WRITE),
      .read_data    (read_data),
      .led_out      (led_out),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_ready    (out_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endfunction

   function automatic void model_reset();
      mled = 0;
      mcyc = 0;
      movf = 0;
      mq.delete();
   endfunction

   function automatic void model_read(input logic [31:0] a, output logic [31:0] v, output bit known);
      int unsigned idx;
      known = 1;
      v = 0;
      if (a[31:28] == 4'h0) begin
         idx = (a >> 2) % DEPTH;
         known = mram.exists(idx);
         if (known) v = mram[idx];
      end else if (a[31:28] == 4'h1) begin
         case ((a >> 2) & 3)
            0: v = mled;
            1: v = mcyc;
            2: v = 0;
            default: begin
`ifdef DMEM_OUT_FIFO_EN
               v = {movf, 31'(mq.size())};
`else
               v = 0;
`endif
            end
         endcase
      end
   endfunction

   function automatic void model_commit(input logic [31:0] a, input logic [31:0] wd, input bit we, input bit rdy);
      bit clr = 0;
      bit push = 0;
      bit pop = 0;
`ifdef DMEM_OUT_FIFO_EN
      pop = (mq.size() > 0) && rdy;
`endif
      if (we && a[31:28] == 4'h0) mram[(a >> 2) % DEPTH] = wd;
      if (we && a[31:28] == 4'h1) begin
         case ((a >> 2) & 3)
            0: mled = wd;
            1: clr = 1;
            2: push = 1;
            default: movf = 0;
         endcase
      end
      mcyc = clr ? 32'd0 : mcyc + 32'd1;
`ifdef DMEM_OUT_FIFO_EN
      if (pop) void'(mq.pop_front());
      if (push) begin
         if (mq.size() < FD) mq.push_back(wd);
         else movf = 1;
      end
`else
      if (push || pop) movf = 0;
`endif
   endfunction

   // One bus cycle: drive, check pre-edge outputs, clock, update model
   task automatic cyc(input logic [31:0] a, input logic [31:0] wd, input bit we, input bit rdy,
                      input bit exp_en, input logic [31:0] exp_rd, input string tag);
      logic [31:0] er;
      bit known;
      DMEM_address = a;
      write_data   = wd;
      DMEM_WRITE   = we;
      out_ready    = rdy;
      #1;
      model_read(a, er, known);
      if (exp_en) chk({tag, "_rd"}, read_data, exp_rd);
      if (known) chk({tag, "_model_rd"}, read_data, er);
      chk({tag, "_led"}, led_out, mled);
      chk({tag, "_valid"}, 32'(out_valid), 32'(mq.size() > 0));
`ifdef DMEM_OUT_FIFO_EN
      if (mq.size() > 0) chk({tag, "_head"}, out_data, mq[0]);
`else
      chk({tag, "_head"}, out_data, 32'd0);
`endif
      @(posedge clock);
      model_commit(a, wd, we, rdy);
      #1;
   endtask

   // Asynchronous reset in the middle of a cycle; RAM must survive
   task automatic mid_reset(input logic [31:0] ram_exp);
      DMEM_WRITE = 0;
      out_ready  = 0;
      reset      = 1;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_led", led_out, 32'd0);
      DMEM_address = 32'h1000_000C;
      #1;
      chk("arst_stat", read_data, 32'd0);
      DMEM_address = 32'h0000_0010;
      #1;
      chk("arst_ram", read_data, ram_exp);
      model_reset();
      @(posedge clock);
      @(posedge clock);
      #1;
      reset = 0;
   endtask

   function automatic logic [31:0] rand_addr();
      int unsigned kind = $urandom_range(0, 9);
      logic [31:0] a;
      if (kind < 5) begin
         a = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      end else if (kind < 9) begin
         a = 32'h1000_0000 | ($urandom & 32'h0FFF_FFF0) | (32'($urandom_range(0, 3)) << 2);
      end else begin
         a = {4'($urandom_range(2, 15)), 28'($urandom)};
      end
      return a;
   endfunction

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          we;
      bit          exp_en;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs [15];

   initial begin
      logic [31:0] drain_exp [8];
      vecs[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 1, 0, 32'h0};
      vecs[1]  = '{32'h0000_0010, 32'h0,         0, 1, 32'hDEAD_BEEF};
      vecs[2]  = '{32'h0000_0012, 32'h0,         0, 1, 32'hDEAD_BEEF};
      vecs[3]  = '{32'h0000_0010, 32'h1234_5678, 1, 1, 32'hDEAD_BEEF};
      vecs[4]  = '{32'h0000_0010, 32'h0,         0, 1, 32'h1234_5678};
      vecs[5]  = '{32'h0000_1010, 32'h0,         0, 1, 32'h1234_5678};
      vecs[6]  = '{32'h0FFF_F010, 32'h0,         0, 1, 32'h1234_5678};
      vecs[7]  = '{32'h1000_0000, 32'h0000_00A5, 1, 1, 32'h0};
      vecs[8]  = '{32'h1000_0000, 32'h0,         0, 1, 32'h0000_00A5};
      vecs[9]  = '{32'h1FFF_FFF0, 32'h0,         0, 1, 32'h0000_00A5};
      vecs[10] = '{32'h2000_0000, 32'h0000_FFFF, 1, 1, 32'h0};
      vecs[11] = '{32'hF000_0010, 32'h0,         0, 1, 32'h0};
      vecs[12] = '{32'h1000_0008, 32'h0,         0, 1, 32'h0};
      vecs[13] = '{32'h1000_000C, 32'h0,         0, 1, 32'h0};
      vecs[14] = '{32'h0000_0010, 32'h0,         0, 1, 32'h1234_5678};

      reset = 1;
      DMEM_address = 0;
      write_data = 0;
      DMEM_WRITE = 0;
      out_ready = 0;
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      chk("reset_led", led_out, 32'd0);
      chk("reset_valid", 32'(out_valid), 32'd0);
      reset = 0;

      // CYCLE reads 0 in the first cycle after release, then 1
      cyc(32'h1000_0004, 0, 0, 0, 1, 32'd0, "cyc_first");
      cyc(32'h1000_0004, 0, 0, 0, 1, 32'd1, "cyc_second");

      for (int i = 0; i < 15; i++) begin
         cyc(vecs[i].addr, vecs[i].wdata, vecs[i].we, 0, vecs[i].exp_en, vecs[i].exp_rd,
             $sformatf("vec%0d", i));
      end
      chk("led_after_table", led_out, 32'h0000_00A5);

      cyc(32'h1000_0004, 32'hFFFF_FFFF, 1, 0, 0, 0, "cyc_clear");
      repeat (5) cyc(32'h2000_0000, 0, 0, 0, 1, 32'd0, "cyc_wait");
      cyc(32'h1000_0004, 0, 0, 0, 1, 32'd5, "cyc_five");

`ifdef DMEM_OUT_FIFO_EN
      for (int i = 1; i <= 9; i++) cyc(32'h1000_0008, 32'(i), 1, 0, 0, 0, "fill");
      cyc(32'h1000_000C, 0, 0, 0, 1, 32'h8000_0008, "stat_ovf");
      cyc(32'h1000_000C, 0, 1, 0, 0, 0, "stat_clr");
      cyc(32'h1000_000C, 0, 0, 0, 1, 32'h0000_0008, "stat_cleared");
      chk("full_head", out_data, 32'd1);
      cyc(32'h1000_0008, 32'h55, 1, 1, 0, 0, "push_pop_full");
      cyc(32'h1000_000C, 0, 0, 0, 1, 32'h0000_0008, "stat_pp");
      drain_exp = '{32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'h55};
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("drain%0d", k), out_data, drain_exp[k]);
         chk($sformatf("drain_v%0d", k), 32'(out_valid), 32'd1);
         cyc(32'h2000_0000, 0, 0, 1, 0, 0, "drain");
      end
      chk("drain_empty", 32'(out_valid), 32'd0);
      cyc(32'h1000_0008, 32'hA, 1, 1, 0, 0, "push_empty");
      chk("no_bypass_rise", 32'(out_valid), 32'd1);
      for (int i = 0; i < 3; i++) cyc(32'h1000_0008, 32'(16 + i), 1, 0, 0, 0, "refill");
      cyc(32'h2000_0000, 0, 0, 1, 0, 0, "mid_drain");
      chk("pre_reset_valid", 32'(out_valid), 32'd1);
`else
      cyc(32'h1000_0008, 32'h1, 1, 1, 0, 0, "nofifo_push");
      chk("nofifo_valid", 32'(out_valid), 32'd0);
      cyc(32'h1000_000C, 0, 0, 1, 1, 32'd0, "nofifo_stat");
`endif
      mid_reset(32'h1234_5678);
      cyc(32'h1000_0004, 0, 0, 0, 1, 32'd0, "post_rst_cyc");
      cyc(32'h0000_0010, 0, 0, 0, 1, 32'h1234_5678, "post_rst_ram");

      for (int n = 0; n < 400; n++) begin
         logic [31:0] a;
         bit we;
         a = rand_addr();
         we = ($urandom_range(0, 2) == 0);
         if (a[31:28] == 4'h1 && ((a >> 2) & 3) == 1 && $urandom_range(0, 3) != 0) we = 0;
         cyc(a, $urandom, we, $urandom_range(0, 1) == 1, 0, 0, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined MIPS core: terminates the core's MEM-stage DMEM interface (address, write data, write strobe, read data). Provides word RAM plus a small memory-mapped I/O window with an LED register, a cycle counter and an output FIFO drained by an external consumer over a valid/ready handshake. Sits beside the core at the top level, in place of a bare data RAM.

## Interface
- DEPTH, 1024, RAM size in 32-bit words; power of two.
- FIFO_DEPTH, 8, output FIFO entries; power of two, ≥2.
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all registers, not RAM.
- DMEM_address  in  32  byte address from core MEM stage.
- write_data  in  32  store data from core.
- DMEM_WRITE  in  1  store strobe; write committed on rising clock edge.
- read_data  out  32  load data, combinational from DMEM_address.
- led_out  out  32  LED register contents.
- out_valid  out  1  FIFO head valid.
- out_data  out  32  FIFO head word.
- out_ready  in  1  consumer accepts head this cycle.

## Operation
- Word access only; DMEM_address[1:0] ignored.
- Region select on DMEM_address[31:28]: 4'h0 RAM, 4'h1 MMIO, others unmapped.
- RAM: index = DMEM_address[log2(DEPTH)+1:2]; higher in-region bits ignored (aliasing).
- MMIO by DMEM_address[3:2] (other bits ignored):
  - 0x0 LED: R/W; reset 0.
  - 0x4 CYCLE: read count; write of any value clears to 0.
  - 0x8 FIFO_DATA: write pushes write_data; reads return 0.
  - 0xC FIFO_STAT: read {overflow at bit 31, zeros, count in low bits}; any write clears overflow.
- Unmapped: reads 0, writes ignored.
- FIFO: push when DMEM_WRITE to FIFO_DATA; pop when out_valid && out_ready.
  - Push while full and no pop: word dropped, overflow set (sticky).
  - Push and pop in same cycle while full: both happen, count unchanged, no overflow.
  - Push and pop same cycle otherwise: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
- out_data driven from head entry regardless of out_valid; consumer must qualify with out_valid.
- CYCLE increments by 1 each cycle, wraps 0xFFFFFFFF→0; clear write wins over increment.

## Timing
- Reads: zero latency; read_data valid in same cycle as DMEM_address, reflects state before that cycle's edge (no write-through).
- Writes: visible to reads from next cycle.
- Push into empty FIFO: out_valid rises next cycle (no bypass).
- Reset values: led_out 0, out_valid 0, CYCLE 0, count 0, overflow 0, pointers 0; read_data depends only on address/state (RAM reads undefined until written).
- Reset asserted mid-operation: FIFO contents discarded immediately, out_valid drops asynchronously; RAM retained.
- First cycle after reset release: CYCLE reads 0, reads 1 on the following cycle.

## Configuration
- DMEM_OUT_FIFO_EN defined: FIFO, FIFO_DATA, FIFO_STAT as above.
- Not defined: no FIFO storage; out_valid tied 0, out_data tied 0; FIFO_DATA writes ignored; FIFO_STAT reads 0; out_ready ignored.

## Structure
- Shared package: region codes (RAM 4'h0, MMIO 4'h1), MMIO offsets (LED, CYCLE, FIFO_DATA, FIFO_STAT), overflow bit position.
- One sub-module: dmem_out_fifo (sync FIFO, push/pop/full/empty/count, async reset); instantiated only under DMEM_OUT_FIFO_EN.
- RAM as plain array inside top; no reset on array.

## Test plan
- Store 0xDEADBEEF to 0x00000010, load 0x00000010 next cycle → 0xDEADBEEF; same-cycle load returns old value; load 0x00000012 → 0xDEADBEEF.
- Store 0x000000A5 to 0x10000000 → led_out 0xA5 next cycle; load 0x10000000 → 0xA5; load 0x20000000 → 0.
- Hold out_ready 0, push 9 words 1..9 (FIFO_DEPTH 8) → FIFO_STAT 0x80000008; then out_ready 1 → out_data 1..8 in order, out_valid falls after 8 pops.
- FIFO full, push 0x55 with out_ready 1 same cycle → count stays 8, overflow stays 0, 0x55 emerges last.
- Write CYCLE, wait 5 cycles, read → 5; assert reset mid-drain → out_valid 0 immediately, FIFO_STAT 0, RAM data retained.
- Build without DMEM_OUT_FIFO_EN, push 0x1 → out_valid stays 0, FIFO_STAT reads 0.
